sw_timer_ctrl: RTL

Control sequencer for the three-digit BCD countdown timer. Takes start/stop/clear buttons and generates the one-second enable pulse and the synchronous clear for the digit chain. Watches the digit outputs for 000 and raises the timeout and alarm. Sits between the board buttons and the down-counter digit chain; owns every piece of run-time control of that chain.

---
 rtl/sw_timer_if.sv | 47 ++++
 rtl/sw_timer_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sw_timer_if.sv
// sw_timer_if
// Groups the button inputs, the digit readback from the BCD down-counter
// chain and the control outputs of sw_timer_ctrl into one bundle.
//
// This is not a valid/ready handshake. The buttons are raw asynchronous
// levels. The controller synchronises them and acts on each rising edge
// exactly once. The digits are a level that the counter chain updates on
// the shared clock. Every output is a level, apart from pulse_1sec_o, which
// is a one-cycle strobe.
//
// Signals:
//   start_i, stop_i, clear_i  buttons (asynchronous level, active-high)
//   tim_1_i, tim_2_i, tim_3_i BCD digits: units, tens, hundreds
//   pulse_1sec_o              one-cycle tick, counter-chain enable
//   timer_reset_o             synchronous clear/preset-load for the chain
//   timeout_o                 high while the timer is alarming
//   alarm_o                   buzzer/LED, blinks once per second in alarm
//   state_o                   IDLE=00, RUN=01, PAUSE=10, ALARM=11
//
// Modports:
//   master  the board side: buttons and counter chain
//   slave   the controller
interface sw_timer_if;
  logic       start_i;
  logic       stop_i;
  logic       clear_i;
  logic [3:0] tim_1_i;
  logic [3:0] tim_2_i;
  logic [3:0] tim_3_i;
  logic       pulse_1sec_o;
  logic       timer_reset_o;
  logic       timeout_o;
  logic       alarm_o;
  logic [1:0] state_o;

  modport master (
    output start_i, stop_i, clear_i,
    output tim_1_i, tim_2_i, tim_3_i,
    input  pulse_1sec_o, timer_reset_o, timeout_o, alarm_o, state_o
  );

  modport slave (
    input  start_i, stop_i, clear_i,
    input  tim_1_i, tim_2_i, tim_3_i,
    output pulse_1sec_o, timer_reset_o, timeout_o, alarm_o, state_o
  );
endinterface

// File: rtl/sw_timer_ctrl.sv
// sw_timer_ctrl
// Control sequencer for a three-digit BCD countdown timer. It turns the
// start/stop/clear buttons into run-time control of the down-counter chain.
// It produces the one-second enable tick and the chain's synchronous clear.
// When the digits reach 000, it raises timeout and a blinking alarm.
//
// Parameters:
//   PRESCALE   clock cycles per pulse_1sec_o tick (>= 2)
//   ALARM_SEC  seconds spent in ALARM before returning to IDLE (>= 1)
//
// Ports:
//   clk_i      system clock; all logic runs on the rising edge
//   reset_n_i  asynchronous, active-low reset
//   bus        sw_timer_if.slave: buttons, digits and control outputs
//
// state_o is the FSM state register. It is exported as-is so that
// checkers can follow the sequencer directly.
module sw_timer_ctrl #(
  parameter int PRESCALE  = 50000000,
  parameter int ALARM_SEC = 5
) (
  input logic        clk_i,
  input logic        reset_n_i,
  sw_timer_if.slave  bus
);

  localparam int PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] ASEC_LAST = AW'(ALARM_SEC - 1);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
  localparam logic [AW-1:0] ASEC_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  // ---------------------------------------------------------------------
  // Button conditioning. Bit order is {clear, stop, start}. s1/s2 form the
  // metastability synchroniser. s3 is the previous synchronised level, so
  // a held button gives exactly one event.
  // ---------------------------------------------------------------------
  logic [2:0] btn_s1;
  logic [2:0] btn_s2;
  logic [2:0] btn_s3;
  logic [2:0] btn_ev;
  logic       start_ev;
  logic       stop_ev;
  logic       clear_ev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_s1 <= 3'b000;
      btn_s2 <= 3'b000;
      btn_s3 <= 3'b000;
    end else begin
      btn_s1 <= {bus.clear_i, bus.stop_i, bus.start_i};
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_ev   = btn_s2 & ~btn_s3;
  assign start_ev = btn_ev[0];
  assign stop_ev  = btn_ev[1];
  assign clear_ev = btn_ev[2];

  // ---------------------------------------------------------------------
  // Digit readback and prescaler decode
  // ---------------------------------------------------------------------
  logic          zero;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic          tick;

  assign zero      = (bus.tim_1_i == 4'd0) && (bus.tim_2_i == 4'd0) &&
                     (bus.tim_3_i == 4'd0);
  assign tick      = (pcnt == PCNT_LAST);
  assign pcnt_next = tick ? '0 : (pcnt + PCNT_ONE);

  // ---------------------------------------------------------------------
  // Sequencer. pcnt keeps counting in ALARM so that the blink and the
  // auto-return use the same one-second base as the countdown. pcnt holds
  // in PAUSE, so a resumed second keeps the fraction it had already used.
  // ---------------------------------------------------------------------
  state_t        state;
  logic [AW-1:0] asec;
  logic          alarm_q;
  logic          timeout_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      pcnt      <= '0;
      asec      <= '0;
      alarm_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pcnt      <= '0;
          asec      <= '0;
          alarm_q   <= 1'b0;
          timeout_q <= 1'b0;
          // A clear pressed together with start wins, so the timer stays idle.
          if (!clear_ev && start_ev) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (clear_ev) begin
            state <= ST_IDLE;
            pcnt  <= '0;
          end else if (stop_ev) begin
            // This is still a RUN cycle, so the prescaler advances once more.
            state <= ST_PAUSE;
            pcnt  <= pcnt_next;
          end else if (zero) begin
            state     <= ST_ALARM;
            pcnt      <= '0;
            asec      <= '0;
            alarm_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            pcnt <= pcnt_next;
          end
        end

        ST_PAUSE: begin
          if (clear_ev) begin
            state <= ST_IDLE;
            pcnt  <= '0;
          end else if (start_ev) begin
            state <= ST_RUN;
          end
        end

        ST_ALARM: begin
          if (|btn_ev) begin
            // Any button acknowledges the alarm.
            state     <= ST_IDLE;
            pcnt      <= '0;
            asec      <= '0;
            alarm_q   <= 1'b0;
            timeout_q <= 1'b0;
          end else if (tick) begin
            pcnt <= '0;
            if (asec == ASEC_LAST) begin
              state     <= ST_IDLE;
              asec      <= '0;
              alarm_q   <= 1'b0;
              timeout_q <= 1'b0;
            end else begin
              asec    <= asec + ASEC_ONE;
              alarm_q <= ~alarm_q;
            end
          end else begin
            pcnt <= pcnt_next;
          end
        end

        default: begin
          state <= ST_IDLE;
          pcnt  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The tick and the clear are decoded from registers only, so
  // they settle early in the cycle and are stable at the sampling edge.
  // The tick is masked at zero so that the chain never wraps past 000.
  // ---------------------------------------------------------------------
  assign bus.pulse_1sec_o  = (state == ST_RUN) && tick && !zero;
  assign bus.timer_reset_o = (state == ST_IDLE);
  assign bus.timeout_o     = timeout_q;
  assign bus.alarm_o       = alarm_q;
  assign bus.state_o       = state;

endmodule
